// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD SPI-mode command path: sequencer states, framing
// constants and the command-frame byte selector.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SEND = 3'd2,
        ST_POLL = 3'd3,
        ST_POST = 3'd4,
        ST_RESP = 3'd5
    } seq_state_e;

    localparam logic [7:0] DUMMY_BYTE  = 8'hFF;
    localparam logic [1:0] START_BITS  = 2'b01;
    localparam logic [6:0] CRC7_POLY   = 7'h09;
    localparam int         FRAME_BYTES = 6;

    // Byte sel of the 6-byte command frame; crc is only used for the last byte.
    function automatic logic [7:0] frame_byte(
        input logic [2:0]  sel,
        input logic [5:0]  idx,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        logic [7:0] b;
        case (sel)
            3'd0:    b = {START_BITS, idx};
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            default: b = {crc, 1'b1};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Combinational byte-wide CRC7 update (x^7 + x^3 + 1), message bits taken MSB first.
module sd_crc7 import sd_spi_pkg::*; (
    input  logic [6:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [6:0] crc_out
);

    logic [6:0] stage [0:8];

    assign stage[0] = crc_in;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            logic fb;
            assign fb           = stage[gi][6] ^ byte_in[7 - gi];
            assign stage[gi + 1] = {stage[gi][5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
        end
    endgenerate

    assign crc_out = stage[8];

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Runs one SD SPI-mode command transaction (dummy bytes, CRC7 frame, R1 polling,
// trailing clocks) over a byte-wide SPI engine with a STB/DONE handshake.
module sd_cmd_sequencer import sd_spi_pkg::*; #(
    parameter int RESP_TRIES = 8,
    parameter int PRE_BYTES  = 1
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    input  logic        CMD_STB,
    input  logic [5:0]  CMD_IDX,
    input  logic [31:0] CMD_ARG,
    input  logic        CMD_HOLD,
    output logic        CMD_ACK,
    output logic        BUSY,
    output logic        RESP_STB,
    output logic [7:0]  RESP_R1,
    output logic        RESP_TO,
    output logic        SPI_STB,
    output logic [7:0]  SPI_TX,
    input  logic        SPI_DONE,
    input  logic [7:0]  SPI_RX,
    output logic        CS
);

    localparam logic [7:0] PRE_CNT   = 8'(PRE_BYTES);
    localparam logic [7:0] TRY_CNT   = 8'(RESP_TRIES);
    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

    seq_state_e  state_q, state_d;

    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        hold_q, hold_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  byte_q, byte_d;
    logic [6:0]  crc_q, crc_d;
    logic        pend_q, pend_d;
    logic        cs_q, cs_d;
    logic        ack_q, ack_d;
    logic        stb_q, stb_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  r1_cap_q, r1_cap_d;
    logic        to_cap_q, to_cap_d;
    logic [7:0]  r1_q, r1_d;
    logic        to_q, to_d;

    logic        accept;
    logic        done_ev;
    logic        poll_hit;
    logic        poll_out;
    logic        issue;
    logic [2:0]  send_idx;
    logic [7:0]  send_byte;
    logic [6:0]  crc_next;

    assign accept   = (state_q == ST_IDLE) && CMD_STB;
    assign done_ev  = SPI_DONE && pend_q;
    assign poll_hit = ~SPI_RX[7];
    assign poll_out = (cnt_q >= TRY_CNT);

    // Byte 0 can be issued straight from IDLE, before the index is latched.
    assign send_idx  = (state_q == ST_SEND) ? (byte_q + 3'd1) : 3'd0;
    assign send_byte = frame_byte(send_idx, (state_q == ST_IDLE) ? CMD_IDX : idx_q,
                                  arg_q, crc_q);

    sd_crc7 u_crc7 (
        .crc_in  (crc_q),
        .byte_in (send_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge CLOCK50 or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (CMD_STB) state_d = (PRE_BYTES == 0) ? ST_SEND : ST_PRE;
            ST_PRE:  if (done_ev && (cnt_q == PRE_CNT)) state_d = ST_SEND;
            ST_SEND: if (done_ev && (byte_q == LAST_BYTE)) state_d = ST_POLL;
            ST_POLL: if (done_ev && (poll_hit || poll_out)) state_d = hold_q ? ST_RESP : ST_POST;
            ST_POST: if (done_ev) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue    = (accept || done_ev) &&
                   (state_d inside {ST_PRE, ST_SEND, ST_POLL, ST_POST});
        idx_d    = idx_q;
        arg_d    = arg_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        crc_d    = crc_q;
        cs_d     = cs_q;
        tx_d     = tx_q;
        r1_cap_d = r1_cap_q;
        to_cap_d = to_cap_q;
        r1_d     = r1_q;
        to_d     = to_q;
        ack_d    = accept;
        stb_d    = issue;
        pend_d   = issue ? 1'b1 : (done_ev ? 1'b0 : pend_q);

        if (accept) begin
            idx_d  = CMD_IDX;
            arg_d  = CMD_ARG;
            hold_d = CMD_HOLD;
            cs_d   = 1'b0;
        end

        // cnt counts dummy bytes in PRE and poll bytes in POLL; restarts on entry.
        if (issue) begin
            tx_d  = (state_d == ST_SEND) ? send_byte : DUMMY_BYTE;
            cnt_d = (state_d != state_q) ? 8'd1 :
                    ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
            if (state_d == ST_SEND) begin
                byte_d = send_idx;
            end
        end

        if (issue && (state_d == ST_SEND) && (send_idx != LAST_BYTE)) begin
            crc_d = crc_next;
        end else if ((state_q == ST_IDLE) || (state_q == ST_RESP)) begin
            crc_d = 7'd0;
        end

        if ((state_q == ST_POLL) && done_ev) begin
            if (poll_hit) begin
                r1_cap_d = SPI_RX;
                to_cap_d = 1'b0;
            end else if (poll_out) begin
                r1_cap_d = DUMMY_BYTE;
                to_cap_d = 1'b1;
            end
        end

        if ((state_q == ST_POLL) && (state_d == ST_POST)) begin
            cs_d = 1'b1;
        end

        // Published results only change when the next response strobe starts.
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            r1_d = r1_cap_d;
            to_d = to_cap_d;
        end
    end

    always_ff @(posedge CLOCK50 or posedge RESET) begin
        if (RESET) begin
            idx_q    <= '0;
            arg_q    <= '0;
            hold_q   <= 1'b0;
            cnt_q    <= '0;
            byte_q   <= '0;
            crc_q    <= '0;
            pend_q   <= 1'b0;
            cs_q     <= 1'b1;
            ack_q    <= 1'b0;
            stb_q    <= 1'b0;
            tx_q     <= DUMMY_BYTE;
            r1_cap_q <= DUMMY_BYTE;
            to_cap_q <= 1'b0;
            r1_q     <= DUMMY_BYTE;
            to_q     <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            arg_q    <= arg_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            crc_q    <= crc_d;
            pend_q   <= pend_d;
            cs_q     <= cs_d;
            ack_q    <= ack_d;
            stb_q    <= stb_d;
            tx_q     <= tx_d;
            r1_cap_q <= r1_cap_d;
            to_cap_q <= to_cap_d;
            r1_q     <= r1_d;
            to_q     <= to_d;
        end
    end

    assign CMD_ACK  = ack_q;
    assign BUSY     = (state_q != ST_IDLE);
    assign RESP_STB = (state_q == ST_RESP);
    assign RESP_R1  = r1_q;
    assign RESP_TO  = to_q;
    assign SPI_STB  = stb_q;
    assign SPI_TX   = tx_q;
    assign CS       = cs_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: transaction-level model of the expected byte stream,
// an SPI engine responder and a per-cycle compare process.
module tb_sd_cmd_sequencer;

    localparam int RESP_TRIES = 8;
    localparam int PRE_BYTES  = 1;

    logic        CLOCK50  = 1'b0;
    logic        RESET    = 1'b1;
    logic        CMD_STB  = 1'b0;
    logic [5:0]  CMD_IDX  = '0;
    logic [31:0] CMD_ARG  = '0;
    logic        CMD_HOLD = 1'b0;
    logic        SPI_DONE = 1'b0;
    logic [7:0]  SPI_RX   = '0;
    logic        CMD_ACK, BUSY, RESP_STB, RESP_TO, SPI_STB, CS;
    logic [7:0]  RESP_R1, SPI_TX;

    sd_cmd_sequencer #(.RESP_TRIES(RESP_TRIES), .PRE_BYTES(PRE_BYTES)) dut (
        .CLOCK50  (CLOCK50),
        .RESET    (RESET),
        .CMD_STB  (CMD_STB),
        .CMD_IDX  (CMD_IDX),
        .CMD_ARG  (CMD_ARG),
        .CMD_HOLD (CMD_HOLD),
        .CMD_ACK  (CMD_ACK),
        .BUSY     (BUSY),
        .RESP_STB (RESP_STB),
        .RESP_R1  (RESP_R1),
        .RESP_TO  (RESP_TO),
        .SPI_STB  (SPI_STB),
        .SPI_TX   (SPI_TX),
        .SPI_DONE (SPI_DONE),
        .SPI_RX   (SPI_RX),
        .CS       (CS)
    );

    always #10 CLOCK50 = ~CLOCK50;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    logic [7:0] exp_tx[$];
    logic       exp_cs[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_r1[$];
    logic       exp_to[$];
    logic [7:0] dut_log[$];
    bit         mon_en = 1'b0;
    int         spur_req = 0;

    // CRC7 as the remainder of the 40-bit message times x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] model_crc(input logic [5:0] idx, input logic [31:0] arg);
        logic [46:0] r;
        r = {2'b01, idx, arg, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    task automatic push_xfer(input logic [7:0] tx, input logic cs, input logic [7:0] rx);
        exp_tx.push_back(tx);
        exp_cs.push_back(cs);
        rx_q.push_back(rx);
    endtask

    // nbusy = number of 0xFF poll replies before r1 is returned.
    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic hold,
                             input int nbusy, input logic [7:0] r1,
                             output logic [7:0] er1, output logic eto);
        logic [7:0] fb [6];
        fb[0] = {2'b01, idx};
        fb[1] = arg[31:24];
        fb[2] = arg[23:16];
        fb[3] = arg[15:8];
        fb[4] = arg[7:0];
        fb[5] = {model_crc(idx, arg), 1'b1};
        for (int k = 0; k < PRE_BYTES; k++) push_xfer(8'hFF, 1'b0, 8'hFF);
        for (int k = 0; k < 6; k++) push_xfer(fb[k], 1'b0, 8'hFF);
        for (int k = 1; k <= RESP_TRIES; k++) begin
            push_xfer(8'hFF, 1'b0, (k <= nbusy) ? 8'hFF : r1);
            if (k > nbusy) break;
        end
        er1 = (nbusy < RESP_TRIES) ? r1 : 8'hFF;
        eto = (nbusy >= RESP_TRIES);
        exp_r1.push_back(er1);
        exp_to.push_back(eto);
        if (!hold) push_xfer(8'hFF, 1'b1, 8'hFF);
    endtask

    // ---------------- SPI engine responder ----------------
    initial begin
        int eng_cnt;
        int eng_lat;
        int rx_rd;
        int spur_done;
        logic [7:0] eng_rx;
        eng_cnt = 0; eng_lat = 0; rx_rd = 0; spur_done = 0; eng_rx = 8'h00;
        forever begin
            @(negedge CLOCK50);
            SPI_DONE = 1'b0;
            SPI_RX   = 8'h00;
            if (RESET) begin
                eng_cnt = 0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        SPI_DONE = 1'b1;
                        SPI_RX   = eng_rx;
                    end
                end else if (spur_req != spur_done) begin
                    spur_done = spur_req;
                    SPI_DONE  = 1'b1;
                    SPI_RX    = 8'h00;
                end
                if (SPI_STB) begin
                    check("one_outstanding", eng_cnt, 0);
                    eng_lat++;
                    eng_cnt = 1 + (eng_lat % 3);
                    if (rx_rd < rx_q.size()) begin
                        eng_rx = rx_q[rx_rd];
                        rx_rd++;
                    end else begin
                        eng_rx = 8'hFF;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int exp_rd  = 0;
    int resp_rd = 0;
    bit m_busy  = 1'b0;

    always @(negedge CLOCK50) begin
        if (RESET) begin
            m_busy = 1'b0;
        end else if (mon_en) begin
            if (CMD_ACK) m_busy = 1'b1;
            check("busy", BUSY, m_busy);
            if (SPI_STB) begin
                dut_log.push_back(SPI_TX);
                if (exp_rd >= exp_tx.size()) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_stb: got SPI_TX 0x%0h, expected no transfer", SPI_TX);
                end else begin
                    check("spi_tx", SPI_TX, exp_tx[exp_rd]);
                    check("cs_at_stb", CS, exp_cs[exp_rd]);
                    exp_rd++;
                end
            end
            if (RESP_STB) begin
                if (resp_rd >= exp_r1.size()) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got RESP_STB with R1 0x%0h, expected none", RESP_R1);
                end else begin
                    check("resp_r1", RESP_R1, exp_r1[resp_rd]);
                    check("resp_to", RESP_TO, exp_to[resp_rd]);
                    resp_rd++;
                end
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_resp(input string name);
        int n;
        n = 0;
        while (!RESP_STB && n < 400) begin
            @(negedge CLOCK50);
            n++;
        end
        if (!RESP_STB) begin
            checks++;
            errors++;
            $display("FAIL %s_resp_timeout: got no RESP_STB in %0d cycles, expected one", name, n);
        end
    endtask

    task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                           input logic hold, input int nbusy, input logic [7:0] r1);
        logic [7:0] er1;
        logic       eto;
        model_cmd(idx, arg, hold, nbusy, r1, er1, eto);
        @(negedge CLOCK50);
        CMD_IDX = idx; CMD_ARG = arg; CMD_HOLD = hold; CMD_STB = 1'b1;
        @(negedge CLOCK50);
        check({name, "_ack"}, CMD_ACK, 1);
        check({name, "_first_stb"}, SPI_STB, 1);
        CMD_STB = 1'b0;
        wait_resp(name);
        @(negedge CLOCK50);
        check({name, "_all_bytes"}, exp_rd, exp_tx.size());
        check({name, "_cs_after"}, CS, hold ? 1'b0 : 1'b1);
        check({name, "_r1_held"}, RESP_R1, er1);
        $display("txn %s idx=%0d arg=0x%08h hold=%0b r1=0x%02h to=%0b",
                 name, idx, arg, hold, RESP_R1, RESP_TO);
    endtask

    initial begin
        logic [7:0] cmd0_seq [10];
        logic [7:0] er1;
        logic       eto;
        int         base;
        int         acks, resps, last_resp, gap, n, stbs;
        cmd0_seq = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};

        repeat (2) @(negedge CLOCK50);
        check("rst_cs", CS, 1);
        check("rst_spi_stb", SPI_STB, 0);
        check("rst_spi_tx", SPI_TX, 8'hFF);
        check("rst_ack", CMD_ACK, 0);
        check("rst_busy", BUSY, 0);
        check("rst_resp_stb", RESP_STB, 0);
        check("rst_r1", RESP_R1, 8'hFF);
        check("rst_to", RESP_TO, 0);
        RESET = 1'b0;
        mon_en = 1'b1;

        check("pin_crc_cmd0", {model_crc(6'd0, 32'h0), 1'b1}, 8'h95);
        check("pin_crc_cmd8", {model_crc(6'd8, 32'h1AA), 1'b1}, 8'h87);
        check("pin_crc_cmd55", {model_crc(6'd55, 32'h0), 1'b1}, 8'h65);
        check("pin_crc_cmd41", {model_crc(6'd41, 32'h4000_0000), 1'b1}, 8'h77);

        base = dut_log.size();
        run_cmd("cmd0", 6'd0, 32'h0, 1'b0, 1, 8'h01);
        check("cmd0_stb_count", dut_log.size() - base, 10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < dut_log.size()) check("cmd0_literal", dut_log[base + i], cmd0_seq[i]);
        end
        check("cmd0_r1", RESP_R1, 8'h01);
        check("cmd0_to", RESP_TO, 0);

        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 1'b0, 0, 8'h01);

        base = dut_log.size();
        run_cmd("cmd58_timeout", 6'd58, 32'h0, 1'b0, RESP_TRIES, 8'h00);
        check("timeout_stb_count", dut_log.size() - base, PRE_BYTES + 6 + RESP_TRIES + 1);
        check("timeout_r1", RESP_R1, 8'hFF);
        check("timeout_to", RESP_TO, 1);

        // Spurious SPI_DONE while idle must not move the sequencer.
        @(negedge CLOCK50);
        spur_req = spur_req + 1;
        repeat (5) begin
            @(negedge CLOCK50);
            check("spur_no_stb", SPI_STB, 0);
            check("spur_no_ack", CMD_ACK, 0);
            check("spur_no_resp", RESP_STB, 0);
        end

        // CMD_STB held high across two transactions.
        model_cmd(6'd55, 32'h0, 1'b0, 0, 8'h01, er1, eto);
        model_cmd(6'd41, 32'h4000_0000, 1'b0, 2, 8'h00, er1, eto);
        @(negedge CLOCK50);
        CMD_IDX = 6'd55; CMD_ARG = 32'h0; CMD_HOLD = 1'b0; CMD_STB = 1'b1;
        acks = 0; resps = 0; last_resp = -100; gap = -1; n = 0;
        while (acks < 2 && n < 800) begin
            @(negedge CLOCK50);
            n++;
            if (CMD_ACK) begin
                acks++;
                if (acks == 1) begin
                    CMD_IDX = 6'd41; CMD_ARG = 32'h4000_0000;
                end else begin
                    gap = n - last_resp;
                    CMD_STB = 1'b0;
                end
            end
            if (RESP_STB) begin
                resps++;
                last_resp = n;
            end
        end
        CMD_STB = 1'b0;
        check("held_second_ack", acks, 2);
        check("held_resps_between", resps, 1);
        check("held_ack_gap", gap, 2);
        $display("txn cmd55 held-strobe r1=0x%02h to=%0b", RESP_R1, RESP_TO);
        wait_resp("cmd41");
        @(negedge CLOCK50);
        check("cmd41_all_bytes", exp_rd, exp_tx.size());
        check("cmd41_r1", RESP_R1, 8'h00);
        $display("txn cmd41 held-strobe r1=0x%02h to=%0b", RESP_R1, RESP_TO);

        run_cmd("cmd17_hold", 6'd17, 32'h0000_1000, 1'b1, 0, 8'h00);
        repeat (3) begin
            @(negedge CLOCK50);
            check("hold_cs_idle", CS, 0);
        end
        run_cmd("cmd13", 6'd13, 32'h0, 1'b0, 0, 8'h00);

        // Reset in the middle of the frame, at the strobe of frame byte 3.
        mon_en = 1'b0;
        @(negedge CLOCK50);
        CMD_IDX = 6'd0; CMD_ARG = 32'h0; CMD_HOLD = 1'b0; CMD_STB = 1'b1;
        stbs = 0; n = 0;
        while (stbs < PRE_BYTES + 4 && n < 200) begin
            @(negedge CLOCK50);
            n++;
            CMD_STB = 1'b0;
            if (SPI_STB) stbs++;
        end
        check("rst_mid_reached", stbs, PRE_BYTES + 4);
        check("rst_mid_cs_low_before", CS, 0);
        RESET = 1'b1;
        #1;
        check("rst_mid_cs", CS, 1);
        check("rst_mid_stb", SPI_STB, 0);
        check("rst_mid_busy", BUSY, 0);
        repeat (3) begin
            @(negedge CLOCK50);
            check("rst_mid_no_resp", RESP_STB, 0);
        end
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK50);
        check("rst_mid_r1", RESP_R1, 8'hFF);
        mon_en = 1'b1;
        base = dut_log.size();
        run_cmd("cmd0_after_reset", 6'd0, 32'h0, 1'b0, 0, 8'h01);
        check("cmd0_after_reset_count", dut_log.size() - base, 9);

        repeat (3) @(negedge CLOCK50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test by 2 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Sequences one SD-card SPI-mode command transaction over the byte-wide SPI engine: chip-select control, leading dummy byte, 6-byte command frame with CRC7, R1 response polling with timeout, trailing clocks. Sits between the card driver's command logic (init, read, write sequencing) and the SPI byte engine, which is the only block toggling SCLK/MOSI.

## Interface
- RESP_TRIES, 8: max poll bytes (NCR) before timeout; 1..255.
- PRE_BYTES, 1: 0xFF bytes sent with CS low before the frame; 0..15.
- CLOCK50  in  1  system clock, all logic rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- CMD_STB  in  1  command request; sampled only while idle.
- CMD_IDX  in  6  command index.
- CMD_ARG  in  32  command argument.
- CMD_HOLD  in  1  1 = keep CS low after response (data phase follows).
- CMD_ACK  out  1  one-cycle pulse: command accepted.
- BUSY  out  1  high from acceptance until RESP_STB cycle inclusive.
- RESP_STB  out  1  one-cycle pulse: response valid.
- RESP_R1  out  8  R1 byte; 0xFF on timeout; held until next RESP_STB.
- RESP_TO  out  1  timeout flag, valid with RESP_STB, held.
- SPI_STB  out  1  one-cycle pulse: start byte transfer.
- SPI_TX  out  8  byte to shift; stable from SPI_STB until SPI_DONE.
- SPI_DONE  in  1  one-cycle pulse from engine: transfer complete.
- SPI_RX  in  8  received byte, valid with SPI_DONE.
- CS  out  1  card chip select, active low.

## Operation
- States: IDLE, PRE, SEND, POLL, POST, RESP.
- IDLE: CMD_STB=1 -> latch IDX/ARG/HOLD, CMD_ACK next cycle, CS driven low, go PRE (or SEND if PRE_BYTES=0). CMD_STB outside IDLE ignored, no ACK.
- PRE: PRE_BYTES transfers of 0xFF.
- SEND: byte0 = {2'b01, IDX}, bytes1..4 = ARG MSB first, byte5 = {CRC7, 1'b1}. CRC7: poly x^7+x^3+1, init 0, over bytes0..4 MSB-first, updated as each byte is issued.
- POLL: send 0xFF; SPI_RX[7]=0 -> capture as R1, RESP_TO=0, go POST. Otherwise count; after RESP_TRIES bytes without valid R1 -> R1=0xFF, RESP_TO=1, go POST.
- POST: HOLD=0 -> CS high, then one 0xFF transfer (8 trailing clocks). HOLD=1 -> skip transfer, CS stays low.
- RESP: RESP_STB pulse, BUSY low next cycle, back to IDLE.
- CS held low by HOLD remains low in IDLE until a later command completes POST with HOLD=0.
- Poll counter 8 bits, saturates; byte counter 3 bits.

## Timing
- Reset values: CS=1, SPI_STB=0, SPI_TX=0xFF, CMD_ACK=0, BUSY=0, RESP_STB=0, RESP_R1=0xFF, RESP_TO=0, state IDLE, HOLD latch 0.
- CMD_STB sampled cycle N -> CMD_ACK and BUSY high cycle N+1; first SPI_STB at N+1.
- SPI_DONE at cycle M -> next SPI_STB earliest M+1; never two SPI_STB without intervening SPI_DONE.
- SPI_DONE while no transfer outstanding: ignored.
- Final SPI_DONE (or POLL hit with HOLD=1) at M -> RESP_STB at M+1; CMD_STB at M+1 not accepted, M+2 accepted.
- RESET mid-transaction: CS high and SPI_STB low immediately (async); no RESP_STB issued; engine must be reset together.

## Structure
- Package sd_spi_pkg: state encoding, DUMMY_BYTE=8'hFF, START_BITS=2'b01, CRC7 polynomial constant; shared with the card driver and init sequencer.
- Sub-module sd_crc7: combinational byte-wide CRC7 update (crc_in, byte_in -> crc_out) with registered accumulator in the sequencer.

## Test plan
- CMD0 ARG=0, PRE_BYTES=1, RX 0xFF then 0x01 -> SPI_TX sequence FF 40 00 00 00 00 95 FF FF FF (10 STBs), RESP_R1=0x01, RESP_TO=0, CS high before last byte.
- CMD8 ARG=0x000001AA -> byte5=0x87; CMD55 ARG=0 -> byte5=0x65; CMD41 ARG=0x40000000 -> byte5=0x77.
- RX always 0xFF, RESP_TRIES=8 -> exactly 8 poll bytes, RESP_R1=0xFF, RESP_TO=1, one RESP_STB.
- CMD17 with CMD_HOLD=1, RX 0x00 on first poll -> no post byte, CS stays low after RESP_STB; following CMD13 HOLD=0 -> CS high in its POST.
- CMD_STB held high continuously and during BUSY -> one ACK per transaction, next ACK 2 cycles after RESP_STB; spurious SPI_DONE in IDLE -> no state change.
- RESET asserted mid-SEND (after byte2) -> CS=1 same cycle, no RESP_STB; new CMD0 after release completes normally.
